// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// legal oversampling ratios and the bit-sampling offsets around mid-bit.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_rx_state_t;

    localparam int unsigned PRESC_X8      = 8;
    localparam int unsigned PRESC_X16     = 16;
    localparam int unsigned PRESC_X32     = 32;
    localparam int unsigned PRESC_DEFAULT = PRESC_X16;

    // Votes are taken at mid-1, mid and mid+1; the result is consumed at mid+2.
    localparam int unsigned SAMPLE_BEFORE_MID = 1;
    localparam int unsigned SAMPLE_AFTER_MID  = 1;
    localparam int unsigned STROBE_AFTER_MID  = 2;

    function automatic logic presc_is_legal(input int unsigned p);
        return (p == PRESC_X8) || (p == PRESC_X16) || (p == PRESC_X32);
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter (0..period-1) and data-bit counter for the
// UART receive FSM. Clear/enable controls come from the FSM.
module uart_rx_edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int PRESC_W = 6,
    parameter int BIT_W   = 3
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [PRESC_W-1:0] period,
    input  logic               edge_clr,
    input  logic               edge_en,
    input  logic               bit_clr,
    input  logic               bit_en,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]   bit_cnt,
    output logic               edge_last
);

    assign edge_last = (edge_cnt == period - PRESC_W'(1));

    // Edge counter wraps at the end of every bit period.
    always_ff @(posedge CLK) begin
        if (RST || edge_clr) begin
            edge_cnt <= '0;
        end else if (edge_en) begin
            edge_cnt <= edge_last ? '0 : edge_cnt + PRESC_W'(1);
        end
    end

    // Bit counter advances once per completed bit period.
    always_ff @(posedge CLK) begin
        if (RST || bit_clr) begin
            bit_cnt <= '0;
        end else if (bit_en && edge_last) begin
            bit_cnt <= bit_cnt + BIT_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: majority-votes each oversampled bit and
// walks start/data/parity/stop, strobing the deserializer once per data bit.
// Parity support is built only when UART_RX_PARITY_EN is defined; otherwise
// PAR_EN/PAR_TYP are ignored and par_err stays 0.
//
// Handshake: deser_en, data_valid, par_err and stp_err are single-cycle
// strobes with no back-pressure; the consumer must take them when high.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    output logic               sampled_bit,
    output logic               deser_en,
    output logic               data_valid,
    output logic               par_err,
    output logic               stp_err,
    output logic               busy
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    uart_rx_state_t state, next_state;

    logic [PRESC_W-1:0] period_q;
    logic [PRESC_W-1:0] edge_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic               edge_last;
    logic               edge_clr, edge_en, bit_clr, bit_en, start_frame;
    logic               samp_a, samp_b;
    logic [PRESC_W-1:0] half, samp_lo, samp_mid, samp_hi, strobe_pt;
    logic               at_strobe;

    assign half      = period_q >> 1;
    assign samp_lo   = half - PRESC_W'(SAMPLE_BEFORE_MID);
    assign samp_mid  = half;
    assign samp_hi   = half + PRESC_W'(SAMPLE_AFTER_MID);
    assign strobe_pt = half + PRESC_W'(STROBE_AFTER_MID);
    assign at_strobe = (edge_cnt == strobe_pt);

    uart_rx_edge_bit_counter #(
        .PRESC_W (PRESC_W),
        .BIT_W   (BIT_W)
    ) u_cnt (
        .CLK       (CLK),
        .RST       (RST),
        .period    (period_q),
        .edge_clr  (edge_clr),
        .edge_en   (edge_en),
        .bit_clr   (bit_clr),
        .bit_en    (bit_en),
        .edge_cnt  (edge_cnt),
        .bit_cnt   (bit_cnt),
        .edge_last (edge_last)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Registered busy flag tracks the state being entered.
    always_ff @(posedge CLK) begin
        if (RST) busy <= 1'b0;
        else     busy <= (next_state != ST_IDLE);
    end

    // Oversampling ratio is frozen for the whole frame; unsupported ratios fall back to 16.
    always_ff @(posedge CLK) begin
        if (RST) begin
            period_q <= PRESC_W'(PRESC_DEFAULT);
        end else if (start_frame) begin
            period_q <= presc_is_legal(32'(prescale)) ? prescale : PRESC_W'(PRESC_DEFAULT);
        end
    end

    // Three-sample capture around mid-bit and 2-of-3 majority vote.
    always_ff @(posedge CLK) begin
        if (RST) begin
            samp_a      <= 1'b0;
            samp_b      <= 1'b0;
            sampled_bit <= 1'b0;
        end else if (state != ST_IDLE) begin
            if (edge_cnt == samp_lo)  samp_a <= RX_IN;
            if (edge_cnt == samp_mid) samp_b <= RX_IN;
            if (edge_cnt == samp_hi) begin
                sampled_bit <= (samp_a & samp_b) | (samp_a & RX_IN) | (samp_b & RX_IN);
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_en_q, par_typ_q, par_acc, par_mis;

    // Frame parity configuration, running XOR of data bits and held mismatch.
    always_ff @(posedge CLK) begin
        if (RST) begin
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            par_acc   <= 1'b0;
            par_mis   <= 1'b0;
        end else begin
            if (start_frame) begin
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
                par_acc   <= 1'b0;
                par_mis   <= 1'b0;
            end
            if (state == ST_DATA && at_strobe) par_acc <= par_acc ^ sampled_bit;
            if (state == ST_PARITY && at_strobe) par_mis <= sampled_bit ^ par_acc ^ par_typ_q;
        end
    end
`else
    logic unused_par_cfg;
    assign unused_par_cfg = PAR_EN ^ PAR_TYP;
`endif

    // Next-state, counter control and output strobes.
    always_comb begin
        next_state  = state;
        edge_clr    = 1'b0;
        edge_en     = 1'b0;
        bit_clr     = 1'b0;
        bit_en      = 1'b0;
        start_frame = 1'b0;
        deser_en    = 1'b0;
        data_valid  = 1'b0;
        par_err     = 1'b0;
        stp_err     = 1'b0;
        case (state)
            ST_IDLE: begin
                edge_clr = 1'b1;
                bit_clr  = 1'b1;
                if (!RX_IN) begin
                    start_frame = 1'b1;
                    next_state  = ST_START;
                end
            end
            ST_START: begin
                edge_en = 1'b1;
                if (edge_last) begin
                    if (sampled_bit) begin
                        next_state = ST_IDLE;
                    end else begin
                        next_state = ST_DATA;
                        bit_clr    = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                edge_en  = 1'b1;
                bit_en   = 1'b1;
                deser_en = at_strobe;
                if (edge_last && bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
                    next_state = par_en_q ? ST_PARITY : ST_STOP;
`else
                    next_state = ST_STOP;
`endif
                end
            end
            ST_PARITY: begin
                edge_en = 1'b1;
                if (edge_last) next_state = ST_STOP;
            end
            ST_STOP: begin
                edge_en = 1'b1;
                // Leave at mid stop bit so an immediately following start bit is caught.
                if (at_strobe) begin
                    stp_err = ~sampled_bit;
`ifdef UART_RX_PARITY_EN
                    par_err    = par_mis;
                    data_valid = sampled_bit & ~par_mis;
`else
                    data_valid = sampled_bit;
`endif
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

endmodule
